pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/dwt_pkg.sv | 20 ++
 rtl/pixel_streamer_if.sv | 31 +++
 rtl/stream_skid_fifo.sv | 61 ++++++
 rtl/pixel_streamer.sv | 154 +++++++++++++++
 tb/tb_pixel_streamer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dwt_pkg.sv
// dwt_pkg: shared types and default image geometry for the DWT front end.
// Holds the pixel streamer state encoding, default frame size and width helper.
package dwt_pkg;

   localparam int DEF_HEIGHT     = 256;
   localparam int DEF_WIDTH      = 256;
   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } stream_state_e;

   // Counter width for n distinct values, never below one bit.
   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// pixel_streamer_if: image memory read port plus AXI-style pixel stream.
// master = streamer (drives mem_en/mem_addr/axi_*), slave = memory + sink.
interface pixel_streamer_if
   import dwt_pkg::*;
#(
   parameter int AW = addr_bits(DEF_HEIGHT * DEF_WIDTH),
   parameter int DW = DEF_DATA_WIDTH
);

   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] axi_out;
   logic          axi_valid;
   logic          axi_ready;
   logic          axi_last;
   logic          axi_eol;

   modport master (
      output mem_en, mem_addr,
      output axi_out, axi_valid, axi_last, axi_eol,
      input  mem_rdata, axi_ready
   );

   modport slave (
      input  mem_en, mem_addr,
      input  axi_out, axi_valid, axi_last, axi_eol,
      output mem_rdata, axi_ready
   );

endinterface

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO whose head is driven straight from registers.
// Ports: clk, rst (async low), push_i/din_i, pop_i, dout_o, valid_o, count_o.
module stream_skid_fifo
   import dwt_pkg::*;
#(
   parameter int W = DEF_DATA_WIDTH + 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         valid_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] slot_q [2];
   logic         rd_q;
   logic         wr_q;
   logic [1:0]   cnt_q;
   logic [1:0]   cnt_d;
   logic         do_push;
   logic         do_pop;

   assign valid_o = (cnt_q != 2'd0);
   assign do_pop  = pop_i && valid_o;
   // A push into a full FIFO is only legal when the head leaves this cycle.
   assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
   assign dout_o  = valid_o ? slot_q[rd_q] : '0;
   assign count_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         if (do_push) begin
            slot_q[wr_q] <= din_i;
            wr_q         <= ~wr_q;
         end
         if (do_pop) begin
            rd_q <= ~rd_q;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pixel_streamer.sv
// pixel_streamer: reads a HEIGHTxWIDTH frame in raster order from image memory
// and streams it out with valid/ready, tagging row ends and the frame end.
// Ports: clk, rst (async low), start, busy, done, bus (pixel_streamer_if.master).
// Build option: PIXEL_STREAMER_EOL_EN enables axi_eol and its column counter;
// without it axi_eol is held at 0.
module pixel_streamer
   import dwt_pkg::*;
#(
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   pixel_streamer_if.master bus
);

   localparam int NPIX = HEIGHT * WIDTH;
   localparam int AW   = addr_bits(NPIX);
   localparam int TW   = DATA_WIDTH + 2;

   stream_state_e state_q;
   logic [AW-1:0] addr_q;
   logic          infl_q;
   logic          infl_last_q;
   logic          infl_eol_q;
   logic          busy_q;
   logic          done_q;

   logic [1:0]    fifo_cnt;
   logic [1:0]    occ;
   logic          issue;
   logic          pop;
   logic          last_rd;
   logic          eol_rd;
   logic [TW-1:0] head;
   logic          head_valid;
   logic [TW-1:0] push_data;

   // Entry layout: {eol, last, pixel}.
   assign push_data = {infl_eol_q, infl_last_q, bus.mem_rdata};

   stream_skid_fifo #(
      .W (TW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (infl_q),
      .din_i   (push_data),
      .pop_i   (pop),
      .dout_o  (head),
      .valid_o (head_valid),
      .count_o (fifo_cnt)
   );

   assign pop = head_valid && bus.axi_ready;

   // Entries held plus the read whose data lands next cycle.
   assign occ = fifo_cnt + {1'b0, infl_q};

   assign issue = (state_q == ST_STREAM) &&
                  ((occ < 2'd2) || ((occ == 2'd2) && pop));

   assign last_rd = (addr_q == AW'(NPIX - 1));

`ifdef PIXEL_STREAMER_EOL_EN
   localparam int CW = addr_bits(WIDTH);

   logic [CW-1:0] col_q;
   logic [CW-1:0] col_d;

   always_comb begin
      col_d = col_q;
      if (state_q == ST_IDLE) begin
         col_d = '0;
      end else if (issue) begin
         col_d = (col_q == CW'(WIDTH - 1)) ? '0 : col_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
      end else begin
         col_q <= col_d;
      end
   end

   assign eol_rd = (col_q == CW'(WIDTH - 1));
`else
   assign eol_rd = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         infl_eol_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Tags travel with the read so they meet its data at the FIFO.
         infl_q      <= issue;
         infl_last_q <= issue && last_rd;
         infl_eol_q  <= issue && eol_rd;
         done_q      <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_STREAM;
                  busy_q  <= 1'b1;
                  addr_q  <= '0;
               end
            end
            ST_STREAM: begin
               if (issue) begin
                  if (last_rd) begin
                     state_q <= ST_DRAIN;
                     addr_q  <= '0;
                  end else begin
                     addr_q <= addr_q + AW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (pop && head[DATA_WIDTH]) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_en    = issue;
   assign bus.mem_addr  = addr_q;
   assign bus.axi_out   = head[DATA_WIDTH-1:0];
   assign bus.axi_valid = head_valid;
   assign bus.axi_last  = head[DATA_WIDTH];
   assign bus.axi_eol   = head[DATA_WIDTH+1];
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: directed bench for pixel_streamer on a 4x4 frame.
// A cycle table covers the free-running frame; sequences cover stalls/reset/restart.
`timescale 1ns/1ps
module tb_pixel_streamer;

   localparam int H  = 4;
   localparam int W  = 4;
   localparam int DW = 8;
   localparam int N  = H * W;
   localparam int AW = $clog2(N);
   localparam int NV = 20;

`ifdef PIXEL_STREAMER_EOL_EN
   localparam bit EOL_ON = 1'b1;
`else
   localparam bit EOL_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic busy;
   logic done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pixel_streamer_if #(.AW(AW), .DW(DW)) sif ();

   pixel_streamer #(
      .HEIGHT     (H),
      .WIDTH      (W),
      .DATA_WIDTH (DW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (sif)
   );

   // Image memory: mem[i] = i, data valid one cycle after mem_en, junk otherwise.
   always @(posedge clk) begin
      if (sif.mem_en) sif.mem_rdata <= DW'(sif.mem_addr);
      else            sif.mem_rdata <= 8'hEE;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Stream monitor: order, tags, read addresses and stall stability.
   int          m_beats = 0;
   int          m_reads = 0;
   logic        p_stall = 1'b0;
   logic [DW-1:0] p_out;
   logic        p_last;
   logic        p_eol;

   always @(negedge clk) begin
      int idx;
      if (!rst) begin
         m_beats = 0;
         m_reads = 0;
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            chk("stall_valid", sif.axi_valid, 1);
            chk("stall_data", sif.axi_out, p_out);
            chk("stall_last", sif.axi_last, p_last);
            chk("stall_eol", sif.axi_eol, p_eol);
         end
         if (sif.mem_en) begin
            chk("rd_addr", sif.mem_addr, m_reads % N);
            m_reads++;
         end
         if (sif.axi_valid && sif.axi_ready) begin
            idx = m_beats % N;
            chk("beat_data", sif.axi_out, idx);
            chk("beat_last", sif.axi_last, idx == N - 1);
            chk("beat_eol", sif.axi_eol, EOL_ON && (idx % W == W - 1));
            m_beats++;
         end
         p_stall = sif.axi_valid && !sif.axi_ready;
         p_out   = sif.axi_out;
         p_last  = sif.axi_last;
         p_eol   = sif.axi_eol;
      end
   end

   typedef struct {
      bit start;
      bit ready;
      bit mem_en;
      int addr;
      bit valid;
      int data;
      bit last;
      bit eol;
      bit busy;
      bit done;
   } vec_t;

   vec_t vec [NV];

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_until_done(input int limit, input bit toggle,
                                 output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         if (toggle) sif.axi_ready = ~sif.axi_ready;
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_en"}, sif.mem_en, 0);
      chk({tag, "_mem_addr"}, sif.mem_addr, 0);
      chk({tag, "_axi_out"}, sif.axi_out, 0);
      chk({tag, "_axi_valid"}, sif.axi_valid, 0);
      chk({tag, "_axi_last"}, sif.axi_last, 0);
      chk({tag, "_axi_eol"}, sif.axi_eol, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      bit seen;
      bit found;
      int b0;
      int r0;
      int nz;

      // Free-running frame, cycle by cycle, start sampled at step 0.
      for (int k = 0; k < NV; k++) begin
         vec[k].start  = (k == 0);
         vec[k].ready  = 1'b1;
         vec[k].mem_en = (k >= 1 && k <= 16);
         vec[k].addr   = vec[k].mem_en ? k - 1 : 0;
         vec[k].valid  = (k >= 3 && k <= 18);
         vec[k].data   = vec[k].valid ? k - 3 : 0;
         vec[k].last   = (k == 18);
         vec[k].eol    = EOL_ON && vec[k].valid && ((k - 3) % W == W - 1);
         vec[k].busy   = (k >= 1 && k <= 18);
         vec[k].done   = (k == 19);
      end

      sif.axi_ready = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < NV; k++) begin
         start         = vec[k].start;
         sif.axi_ready = vec[k].ready;
         #1;
         chk($sformatf("vec%0d_mem_en", k), sif.mem_en, vec[k].mem_en);
         chk($sformatf("vec%0d_addr", k), sif.mem_addr, vec[k].addr);
         chk($sformatf("vec%0d_valid", k), sif.axi_valid, vec[k].valid);
         chk($sformatf("vec%0d_data", k), sif.axi_out, vec[k].data);
         chk($sformatf("vec%0d_last", k), sif.axi_last, vec[k].last);
         chk($sformatf("vec%0d_eol", k), sif.axi_eol, vec[k].eol);
         chk($sformatf("vec%0d_busy", k), busy, vec[k].busy);
         chk($sformatf("vec%0d_done", k), done, vec[k].done);
         @(posedge clk); #1;
      end
      start = 1'b0;

      // Ready toggling every cycle.
      b0 = m_beats;
      sif.axi_ready = 1'b1;
      pulse_start();
      run_until_done(200, 1'b1, seen);
      chk("toggle_done", seen, 1);
      chk("toggle_beats", m_beats - b0, N);
      chk("toggle_idle_valid", sif.axi_valid, 0);
      chk("toggle_idle_busy", busy, 0);

      // Sink stalled for 20 cycles after start.
      sif.axi_ready = 1'b0;
      b0 = m_beats;
      r0 = m_reads;
      nz = 0;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (sif.axi_out != 0) nz++;
      end
      chk("hold_reads_le2", (m_reads - r0) <= 2, 1);
      chk("hold_out_zero", nz, 0);
      chk("hold_valid", sif.axi_valid, 1);
      chk("hold_no_beats", m_beats - b0, 0);
      sif.axi_ready = 1'b1;
      run_until_done(60, 1'b0, seen);
      chk("hold_done", seen, 1);
      chk("hold_beats", m_beats - b0, N);

      // Asynchronous reset while pixel 7 is on the bus.
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (sif.axi_valid && sif.axi_out == 7) found = 1'b1;
      end
      chk("rst_reach_beat7", found, 1);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_no_reads", m_reads, 0);
      chk("post_rst_busy", busy, 0);
      pulse_start();
      run_until_done(60, 1'b0, seen);
      chk("post_rst_done", seen, 1);
      chk("post_rst_beats", m_beats, N);

      // Start held high: one frame, then the next begins right after done.
      b0 = m_beats;
      r0 = m_reads;
      start = 1'b1;
      run_until_done(60, 1'b0, seen);
      chk("held_done1", seen, 1);
      chk("held_reads1", m_reads - r0, N);
      @(posedge clk); #1;
      chk("held_restart_mem_en", sif.mem_en, 1);
      chk("held_restart_addr", sif.mem_addr, 0);
      chk("held_restart_busy", busy, 1);
      start = 1'b0;
      run_until_done(60, 1'b0, seen);
      chk("held_done2", seen, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("held_beats", m_beats - b0, 2 * N);
      chk("held_reads", m_reads - r0, 2 * N);
      chk("held_final_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
